// File: rtl/mixer_pkg.sv
// Shared mixer-chain types: sample/gain widths, unity gain and gain-ramp states.
package mixer_pkg;
    localparam int DATA_W     = 24;
    localparam int GAIN_W     = 8;
    localparam int GAIN_FRAC  = 7;
    localparam int GAIN_UNITY = 128;

    typedef logic signed [DATA_W-1:0] sample_t;
    typedef logic [GAIN_W-1:0]        gain_t;

    typedef enum logic [1:0] {
        STEADY,
        RAMP_UP,
        RAMP_DOWN
    } ramp_state_t;
endpackage

// File: rtl/sat_mul.sv
// Combinational signed sample x unsigned Q1.FRAC gain, floor shift, saturate.
module sat_mul #(
    parameter int DATA_W = 24,
    parameter int GAIN_W = 8,
    parameter int FRAC_W = 7
) (
    input  logic signed [DATA_W-1:0] a,
    input  logic [GAIN_W-1:0]        g,
    output logic signed [DATA_W-1:0] y,
    output logic                     overflow
);
    localparam int PW = DATA_W + GAIN_W + 1;
    localparam logic signed [DATA_W-1:0] MAXV = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] MINV = {1'b1, {(DATA_W-1){1'b0}}};

    logic signed [GAIN_W:0]         g_s;
    logic signed [PW-1:0]           shifted;
    logic [PW-DATA_W:0]             hi_bits;

    assign g_s     = {1'b0, g};
    // Product always fits in PW bits, so no truncation before the shift.
    assign shifted = (PW'(a) * PW'(g_s)) >>> FRAC_W;
    assign hi_bits = shifted[PW-1:DATA_W-1];

    always_comb begin
        overflow = !((&hi_bits) || (~|hi_bits));
        if (overflow) begin
            y = shifted[PW-1] ? MINV : MAXV;
        end else begin
            y = shifted[DATA_W-1:0];
        end
    end
endmodule

// File: rtl/gain_ramp.sv
// Ramped, saturating output gain stage with valid/ready on both sides.
// Optional sticky clip flag built only when GAIN_RAMP_CLIP_EN is defined.
module gain_ramp #(
    parameter int DATA_W       = 24,
    parameter int GAIN_W       = 8,
    parameter int RAMP_SAMPLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic [GAIN_W-1:0] gain,
    input  logic              mute,
    output logic              clip,
    input  logic              clip_clr
);
    import mixer_pkg::*;

    localparam int CNT_W = (RAMP_SAMPLES > 1) ? $clog2(RAMP_SAMPLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAMP_SAMPLES - 1);

    ramp_state_t              state;
    logic [GAIN_W-1:0]        cur_gain;
    logic [CNT_W-1:0]         ramp_cnt;
    logic [GAIN_W-1:0]        tgt;
    logic [GAIN_W-1:0]        step_gain;
    logic                     gain_up;
    logic                     gain_dn;
    logic                     accept;
    logic signed [DATA_W-1:0] sat_y;
    logic                     sat_ovf;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        tgt       = mute ? '0 : gain;
        gain_up   = tgt > cur_gain;
        gain_dn   = tgt < cur_gain;
        step_gain = gain_up ? cur_gain + 1'b1 : cur_gain - 1'b1;
    end

    sat_mul #(
        .DATA_W (DATA_W),
        .GAIN_W (GAIN_W),
        .FRAC_W (GAIN_FRAC)
    ) u_sat_mul (
        .a        (in_data),
        .g        (cur_gain),
        .y        (sat_y),
        .overflow (sat_ovf)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= STEADY;
            cur_gain  <= GAIN_W'(GAIN_UNITY);
            ramp_cnt  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                out_data  <= sat_y;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                STEADY: begin
                    if (gain_up) begin
                        state    <= RAMP_UP;
                        ramp_cnt <= '0;
                    end else if (gain_dn) begin
                        state    <= RAMP_DOWN;
                        ramp_cnt <= '0;
                    end
                end
                default: begin
                    if (!gain_up && !gain_dn) begin
                        state <= STEADY;
                    end else if (accept && ramp_cnt == CNT_LAST) begin
                        // This sample already used the old gain; the step lands after it.
                        cur_gain <= step_gain;
                        ramp_cnt <= '0;
                        if (step_gain == tgt) begin
                            state <= STEADY;
                        end else begin
                            state <= gain_up ? RAMP_UP : RAMP_DOWN;
                        end
                    end else begin
                        if (accept) begin
                            ramp_cnt <= ramp_cnt + 1'b1;
                        end
                        state <= gain_up ? RAMP_UP : RAMP_DOWN;
                    end
                end
            endcase
        end
    end

`ifdef GAIN_RAMP_CLIP_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            clip <= 1'b0;
        end else if (accept && sat_ovf) begin
            clip <= 1'b1;
        end else if (clip_clr) begin
            clip <= 1'b0;
        end
    end
`else
    logic unused_clip;
    assign clip        = 1'b0;
    assign unused_clip = &{1'b0, clip_clr, sat_ovf};
`endif
endmodule

// File: tb/tb_gain_ramp.sv
// Directed bench for gain_ramp with RAMP_SAMPLES=4: table vectors plus ramp/backpressure/reset/mute sequences.
module tb_gain_ramp;
    localparam int RS = 4;
`ifdef GAIN_RAMP_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  gain;
    logic        mute;
    logic        clip;
    logic        clip_clr;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cur_model = 128;

    typedef struct {
        logic [7:0]  g;
        logic [23:0] din;
        logic [23:0] dout;
        logic        clp;
    } vec_t;
    vec_t tbl[14];

    gain_ramp #(.DATA_W(24), .GAIN_W(8), .RAMP_SAMPLES(RS)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .gain      (gain),
        .mute      (mute),
        .clip      (clip),
        .clip_clr  (clip_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // One isolated sample: output one cycle after accept, then drains.
    task automatic send_chk(input string name, input logic [23:0] d,
                            input logic [23:0] exp_d, input logic exp_c);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
        $display("txn %s: in=0x%06h out=0x%06h exp=0x%06h clip=%0b", name, d, out_data, exp_d, clip);
        chk({name, ".valid"}, 32'(out_valid), 32'd1);
        chk({name, ".data"}, 32'(out_data), 32'(exp_d));
        chk({name, ".clip"}, 32'(clip), 32'(exp_c & CLIP_EN));
        @(negedge clk);
        chk({name, ".drain"}, 32'(out_valid), 32'd0);
    endtask

    task automatic run_accepts(input int n, input logic [23:0] d);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = d;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    // Idle cycle lets the FSM leave STEADY before accepts start counting.
    task automatic set_gain(input logic [7:0] g);
        gain = g;
        @(negedge clk);
    endtask

    task automatic settle(input logic [7:0] g);
        int diff;
        diff = (int'(g) > cur_model) ? int'(g) - cur_model : cur_model - int'(g);
        set_gain(g);
        run_accepts(diff * RS, 24'h0);
        cur_model = int'(g);
    endtask

    initial begin
        logic [23:0] ramp_exp[13];
        reset     = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        gain      = 8'd128;
        mute      = 1'b0;
        clip_clr  = 1'b0;

        tbl[0]  = '{8'd128, 24'h123456, 24'h123456, 1'b0};
        tbl[1]  = '{8'd128, 24'hFEDCBA, 24'hFEDCBA, 1'b0};
        tbl[2]  = '{8'd128, 24'h7FFFFF, 24'h7FFFFF, 1'b0};
        tbl[3]  = '{8'd128, 24'h800000, 24'h800000, 1'b0};
        tbl[4]  = '{8'd128, 24'hFFFFFD, 24'hFFFFFD, 1'b0};
        tbl[5]  = '{8'd64,  24'hFFFFFD, 24'hFFFFFE, 1'b0};
        tbl[6]  = '{8'd64,  24'h000003, 24'h000001, 1'b0};
        tbl[7]  = '{8'd64,  24'h123456, 24'h091A2B, 1'b0};
        tbl[8]  = '{8'd64,  24'h800000, 24'hC00000, 1'b0};
        tbl[9]  = '{8'd64,  24'hFFFFFF, 24'hFFFFFF, 1'b0};
        tbl[10] = '{8'd255, 24'h000100, 24'h0001FE, 1'b0};
        tbl[11] = '{8'd255, 24'h7FFFFF, 24'h7FFFFF, 1'b1};
        tbl[12] = '{8'd255, 24'h800000, 24'h800000, 1'b1};
        tbl[13] = '{8'd255, 24'hFFFF00, 24'hFFFE02, 1'b1};

        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.out_data", 32'(out_data), 32'd0);
        chk("rst.clip", 32'(clip), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd1);

        // Ramp 128 -> 130, four accepts per LSB, continuous valid.
        for (int i = 0; i < 13; i++) begin
            ramp_exp[i] = (i < 4) ? 24'h000100 : (i < 8) ? 24'h000102 : 24'h000104;
        end
        set_gain(8'd130);
        for (int i = 0; i < 13; i++) begin
            in_valid = 1'b1;
            in_data  = 24'h000100;
            @(negedge clk);
            $display("txn ramp[%0d]: out=0x%06h exp=0x%06h", i, out_data, ramp_exp[i]);
            chk($sformatf("ramp[%0d]", i), 32'(out_data), 32'(ramp_exp[i]));
        end
        in_valid  = 1'b0;
        cur_model = 130;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            if (int'(tbl[i].g) != cur_model) settle(tbl[i].g);
            send_chk($sformatf("tbl[%0d]", i), tbl[i].din, tbl[i].dout, tbl[i].clp);
        end

        // Sticky clip: clear, then set and clear in the same cycle.
        clip_clr = 1'b1;
        @(negedge clk);
        clip_clr = 1'b0;
        chk("clip.clr", 32'(clip), 32'd0);
        clip_clr = 1'b1;
        send_chk("clip.setwins", 24'h7FFFFF, 24'h7FFFFF, 1'b1);
        clip_clr = 1'b0;
        chk("clip.clr2", 32'(clip), 32'd0);

        // Backpressure mid-ramp 255 -> 254: stall must not advance the ramp.
        set_gain(8'd254);
        in_valid = 1'b1;
        in_data  = 24'h000100;
        @(negedge clk);
        chk("bp.s1", 32'(out_data), 32'h0001FE);
        in_data = 24'h000200;
        @(negedge clk);
        chk("bp.s2", 32'(out_data), 32'h0003FC);
        in_data = 24'h000300;
        @(negedge clk);
        chk("bp.s3", 32'(out_data), 32'h0005FA);
        out_ready = 1'b0;
        in_data   = 24'h000400;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            $display("txn bp.stall[%0d]: in_ready=%0b out=0x%06h", i, in_ready, out_data);
            chk("bp.in_ready", 32'(in_ready), 32'd0);
            chk("bp.hold", 32'(out_data), 32'h0005FA);
            chk("bp.hold_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp.s4", 32'(out_data), 32'h0007F8);
        in_data = 24'h000500;
        @(negedge clk);
        chk("bp.s5", 32'(out_data), 32'h0009EC);
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp.drain", 32'(out_valid), 32'd0);
        cur_model = 254;

        // Reset while ramping down through 100 (with clip set if built).
        set_gain(8'd90);
        in_valid = 1'b1;
        in_data  = 24'h7FFFFF;
        @(negedge clk);
        chk("rr.sat", 32'(out_data), 32'h7FFFFF);
        chk("rr.clip", 32'(clip), 32'(CLIP_EN));
        run_accepts(615, 24'h0);
        gain     = 8'd128;
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 24'h000100;
        @(negedge clk);
        chk("rr.out_valid", 32'(out_valid), 32'd0);
        chk("rr.out_data", 32'(out_data), 32'd0);
        chk("rr.clip0", 32'(clip), 32'd0);
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        send_chk("rr.unity", 24'h000100, 24'h000100, 1'b0);
        cur_model = 128;

        // Mute ramps 128 -> 0 in 512 accepts, unmute ramps back.
        mute = 1'b1;
        @(negedge clk);
        run_accepts(511, 24'h0);
        send_chk("mute.last", 24'h7FFFFF, 24'h00FFFF, 1'b0);
        send_chk("mute.zero", 24'h7FFFFF, 24'h000000, 1'b0);
        mute = 1'b0;
        @(negedge clk);
        run_accepts(511, 24'h0);
        send_chk("unmute.last", 24'h000100, 24'h0000FE, 1'b0);
        send_chk("unmute.unity", 24'h000100, 24'h000100, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
